// File: rtl/dc_ipu_addr_gen_pkg.sv
// Shared types and constants for the IPU texture-position generator.
package dc_ipu_pkg;

  localparam int DC_DATA_WIDTH  = 24;
  localparam int DC_FRACT_WIDTH = 12;
  localparam int DC_CNT_WIDTH   = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Fixed-point 1.0 in the position format
  function automatic logic [DC_DATA_WIDTH-1:0] fixed_one();
    logic [DC_DATA_WIDTH-1:0] one;
    one = {{(DC_DATA_WIDTH-1){1'b0}}, 1'b1};
    return one << DC_FRACT_WIDTH;
  endfunction

endpackage

// File: rtl/dc_ipu_addr_gen_if.sv
// Valid/ready position stream from the generator to the address-compute final stage.
interface dc_ipu_addr_gen_if
  import dc_ipu_pkg::*;
#(
  parameter int DATA_WIDTH = DC_DATA_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/dc_ipu_addr_gen_acc.sv
// Position accumulator: loads the line offset, then adds the step per accepted beat.
module dc_ipu_addr_gen_acc
  import dc_ipu_pkg::*;
#(
  parameter int DATA_WIDTH = DC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  step_en,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  carry
);

  logic [DATA_WIDTH:0] sum;

  // The extra top bit is the wrap indicator the top folds into ovf
  assign sum   = {1'b0, acc} + {1'b0, step};
  assign carry = sum[DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (step_en) begin
      acc <= sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dc_ipu_addr_gen.sv
// Per-line texture-position generator: emits offset + k*step for k = 0..count-1
// over a valid/ready stream, with registered outputs and a sticky overflow flag.
module dc_ipu_addr_gen
  import dc_ipu_pkg::*;
#(
  parameter int DATA_WIDTH  = DC_DATA_WIDTH,
  parameter int FRACT_WIDTH = DC_FRACT_WIDTH,
  parameter int CNT_WIDTH   = DC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  cfg_start,
  input  logic [DATA_WIDTH-1:0] cfg_offset,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  dc_ipu_addr_gen_if.master     out_if,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
    $error("FRACT_WIDTH must leave at least one integer bit");
  end

  state_t                state;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] acc;
  logic                  carry;
  logic                  accept;
  logic                  is_last;
  logic                  acc_load;
  logic                  acc_step;

  assign accept   = valid_q && out_if.out_ready;
  assign is_last  = (remaining == CNT_WIDTH'(1));
  assign acc_load = !clr && (state == IDLE) && cfg_start && (cfg_count != '0);
  assign acc_step = !clr && accept;

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = acc;
  assign out_if.out_last  = valid_q && is_last;

  dc_ipu_addr_gen_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_acc (
    .clk      (clk),
    .nreset   (nreset),
    .load     (acc_load),
    .load_val (cfg_offset),
    .step_en  (acc_step),
    .step     (step_q),
    .acc      (acc),
    .carry    (carry)
  );

  // clr aborts without a done pulse but keeps ovf for software to inspect
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      step_q    <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state     <= IDLE;
        valid_q   <= 1'b0;
        busy      <= 1'b0;
        remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              ovf <= 1'b0;
              if (cfg_count != '0) begin
                step_q    <= cfg_step;
                remaining <= cfg_count;
                state     <= RUN;
                valid_q   <= 1'b1;
                busy      <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (accept) begin
              remaining <= remaining - 1'b1;
              if (carry) begin
                ovf <= 1'b1;
              end
              if (is_last) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dc_ipu_addr_gen.sv
// Directed and randomized bench for dc_ipu_addr_gen against an arithmetic position model.
module tb_dc_ipu_addr_gen;
  import dc_ipu_pkg::*;

  localparam int DW = 24;
  localparam int CW = 12;
  localparam logic [63:0] MASK = 64'h0000_0000_00FF_FFFF;

  logic          clk;
  logic          nreset;
  logic          clr;
  logic          cfg_start;
  logic [DW-1:0] cfg_offset;
  logic [DW-1:0] cfg_step;
  logic [CW-1:0] cfg_count;
  logic          busy;
  logic          done;
  logic          ovf;

  int vectors;
  int miscompares;

  dc_ipu_addr_gen_if #(.DATA_WIDTH(DW)) bus ();

  dc_ipu_addr_gen #(
    .DATA_WIDTH  (DW),
    .FRACT_WIDTH (12),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .clr        (clr),
    .cfg_start  (cfg_start),
    .cfg_offset (cfg_offset),
    .cfg_step   (cfg_step),
    .cfg_count  (cfg_count),
    .out_if     (bus),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: position k of a line is (offset + k*step) mod 2^24
  function automatic logic [63:0] expPos(input logic [63:0] off, input logic [63:0] stp, input int k);
    return (off + stp * 64'(k)) & MASK;
  endfunction

  // Model: overflow after j accepted beats is set once the true sum passed 2^24
  function automatic logic [63:0] expOvf(input logic [63:0] off, input logic [63:0] stp, input int j);
    return 64'(((off + stp * 64'(j)) >> DW) != 0);
  endfunction

  task automatic applyStimulus(input logic [DW-1:0] off, input logic [DW-1:0] stp, input logic [CW-1:0] cnt);
    cfg_offset = off;
    cfg_step   = stp;
    cfg_count  = cnt;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    cfg_offset = DW'($urandom);
    cfg_step   = DW'($urandom);
    cfg_count  = CW'($urandom);
  endtask

  // Runs one full line; stall_at/stall_len hold ready low at a given beat,
  // ready_pct randomizes ready otherwise, junk_start pokes cfg_start mid-line.
  task automatic runLine(input logic [DW-1:0] off, input logic [DW-1:0] stp, input int cnt,
                         input int ready_pct, input int stall_at, input int stall_len,
                         input bit junk_start);
    int k;
    int stalls;
    int cycles;
    applyStimulus(off, stp, CW'(cnt));
    if (cnt == 0) begin
      checkOutput("zero_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("zero_done", 64'(done), 64'd1);
      checkOutput("zero_busy", 64'(busy), 64'd0);
      checkOutput("zero_ovf", 64'(ovf), 64'd0);
      tick();
      checkOutput("zero_done_clear", 64'(done), 64'd0);
      checkOutput("zero_valid_after", 64'(bus.out_valid), 64'd0);
      return;
    end
    k = 0;
    stalls = 0;
    cycles = 0;
    while (k < cnt && cycles < 4000) begin
      if (k == stall_at && stalls < stall_len) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
      end
      if (junk_start && $urandom_range(4) == 0) begin
        cfg_start  = 1'b1;
        cfg_offset = DW'($urandom);
        cfg_step   = DW'($urandom);
        cfg_count  = CW'($urandom);
      end else begin
        cfg_start = 1'b0;
      end
      #1;
      checkOutput("valid", 64'(bus.out_valid), 64'd1);
      checkOutput("data", 64'(bus.out_data), expPos(64'(off), 64'(stp), k));
      checkOutput("last", 64'(bus.out_last), 64'(k == cnt - 1));
      checkOutput("busy", 64'(busy), 64'd1);
      checkOutput("ovf_mid", 64'(ovf), expOvf(64'(off), 64'(stp), k));
      if (bus.out_ready) k++;
      cycles++;
      tick();
    end
    if (k < cnt) begin
      miscompares++;
      $error("[TB] FAIL line_timeout observed=%0d expected=%0d", k, cnt);
    end
    cfg_start     = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("end_done", 64'(done), 64'd1);
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("end_ovf", 64'(ovf), expOvf(64'(off), 64'(stp), cnt));
    tick();
    checkOutput("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    int lines;
    vectors     = 0;
    miscompares = 0;
    nreset      = 1'b0;
    clr         = 1'b0;
    cfg_start   = 1'b0;
    cfg_offset  = '0;
    cfg_step    = '0;
    cfg_count   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    nreset = 1'b1;
    tick();

    $display("[TB] basic line");
    runLine(24'h001000, 24'h000800, 4, 100, -1, 0, 1'b0);

    $display("[TB] backpressure on second beat");
    runLine(24'h001000, 24'h000800, 4, 100, 1, 3, 1'b0);

    $display("[TB] zero-count line");
    runLine(24'h123456, 24'h000100, 0, 100, -1, 0, 1'b0);

    $display("[TB] clr mid-line");
    applyStimulus(24'h010000, 24'h000100, 12'd8);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    #1;
    checkOutput("clr_pre_data", 64'(bus.out_data), 64'h010200);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("clr_last", 64'(bus.out_last), 64'd0);
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_done", 64'(done), 64'd0);
    tick();
    checkOutput("clr_done_late", 64'(done), 64'd0);
    runLine(24'h000400, 24'h000400, 2, 100, -1, 0, 1'b0);

    $display("[TB] wrap and sticky ovf");
    runLine(24'hFFF000, 24'h002000, 2, 100, -1, 0, 1'b0);
    tick();
    checkOutput("ovf_sticky", 64'(ovf), 64'd1);
    runLine(24'h000100, 24'h000100, 1, 100, -1, 0, 1'b0);

    $display("[TB] reset mid-line");
    applyStimulus(24'hFFF000, 24'h002000, 12'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("pre_rst_ovf", 64'(ovf), 64'd1);
    nreset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    nreset = 1'b1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_rst_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("post_rst_done", 64'(done), 64'd0);
    end
    bus.out_ready = 1'b0;

    $display("[TB] randomized lines");
    lines = 0;
    while (lines < 25) begin
      runLine(DW'($urandom), DW'($urandom_range(24'h3FFFFF)),
              ($urandom_range(7) == 0) ? 0 : int'($urandom_range(16, 1)),
              60, -1, 0, 1'b1);
      lines++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dc_ipu_addr_gen.md
Name: dc_ipu_addr_gen

Overview:
- Fixed-point texture-position generator: per line, emits cfg_count positions out_data = cfg_offset + k*cfg_step, for k = 0..cfg_count-1.
- Sits directly upstream of the IPU address-compute final stage. Drives that stage's in_valid/in_data and honours its in_ready.
- Positions use FRACT_WIDTH fractional bits in the half-pixel-doubled convention. The downstream stage subtracts 1.0 and shifts right by one.

Parameters:
- DATA_WIDTH, 24: width of position, offset and step.
- FRACT_WIDTH, 12: fractional bits within DATA_WIDTH.
- CNT_WIDTH, 12: width of the per-line output count.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous abort to IDLE.
- cfg_start  in  1  single-cycle line-start pulse.
- cfg_offset  in  DATA_WIDTH  first position of the line. Sampled at cfg_start.
- cfg_step  in  DATA_WIDTH  per-output increment. Sampled at cfg_start.
- cfg_count  in  CNT_WIDTH  number of positions in the line. Sampled at cfg_start.
- out_valid  out  1  position available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  fixed-point position.
- out_last  out  1  marks the final position of the line.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after a line completes.
- ovf  out  1  sticky accumulator-overflow flag.

Behaviour:
- Reset and priority:
  - One clock. nreset is synchronous and active-low, sampled only on the rising edge of clk.
  - While nreset is low, the next edge forces: state IDLE; out_valid, out_last, busy, done, ovf = 0; out_data = 0; internal step and remaining = 0.
  - Reset mid-line discards the line; no done pulse.
  - Priority, highest first: nreset, clr, cfg_start, handshake.
- State machine, two states (IDLE, RUN):
  - IDLE, out_valid = 0.
    - cfg_start with cfg_count != 0: latch step, set acc = cfg_offset, remaining = cfg_count, clear ovf, go to RUN.
    - cfg_start with cfg_count == 0: stay IDLE, clear ovf, pulse done on the next cycle. No beats are emitted.
  - RUN, out_valid = 1, busy = 1.
    - out_data = acc.
    - out_last = (remaining == 1).
    - Beat accepted when out_valid && out_ready:
      - acc <= acc + step, modulo 2^DATA_WIDTH.
      - If the addition carries out, ovf <= 1.
      - remaining <= remaining - 1.
    - Beat accepted with out_last = 1: go to IDLE and pulse done for exactly one cycle on the next cycle.
    - cfg_start while in RUN is ignored. The latched config is unchanged.
- Latency: cfg_start sampled at edge N gives out_valid = 1 from cycle N+1. With out_ready held high, one beat per cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops until the beat is accepted.
- clr: the next edge goes to IDLE with out_valid = 0, out_last = 0, busy = 0. No done pulse. ovf is kept.
- Registered outputs: out_valid and out_data come straight from registers, with no combinational path from out_ready. out_last is decoded from the registered remaining value.
- Step is unsigned. Wrap-around follows modulo arithmetic; ovf reports it.
- cfg_* inputs are don't-care except in the cycle cfg_start is sampled.

Decomposition:
- Shared package dc_ipu_pkg:
  - State enum: IDLE, RUN.
  - Function returning the fixed-point 1.0 constant, (1 << FRACT_WIDTH).
- One natural sub-module, dc_ipu_addr_gen_acc: the step accumulator, with load, step-enable and carry-out used for ovf.
- The handshake and counter stay in the top module.

Test Plan:
1. offset 0x001000, step 0x000800, count 4, out_ready = 1 -> out_data 0x001000, 0x001800, 0x002000, 0x002800 on consecutive cycles; out_last on the 4th beat; done pulses one cycle later; busy low afterwards.
2. As test 1, with out_ready low for 3 cycles while 0x001800 is presented -> out_data holds 0x001800 and out_valid stays 1 throughout; the sequence then resumes unchanged, 4 beats total.
3. cfg_start with count 0 -> out_valid never asserts; done = 1 for one cycle, one cycle after the start.
4. count 8, clr after 2 accepted beats -> out_valid = 0 the next cycle; no done pulse. A new cfg_start (offset 0x000400, step 0x000400, count 2) -> out_data 0x000400, 0x000800.
5. offset 0xFFF000, step 0x002000, count 2 -> out_data 0xFFF000, then 0x001000; ovf = 1 and stays set until the next cfg_start clears it.
6. nreset low for one edge mid-line (after 1 beat of count 4) -> next cycle out_valid, out_data, busy, done and ovf are all 0; no further beats are emitted until a new cfg_start.
